addsub_sequencer: RTL and testbench

Multi-cycle W-bit adder/subtractor controller. It time-multiplexes a single 2-bit add/sub slice (two full-adder cells, operand-B XOR inversion, registered carry) across the operand, least-significant pair first, one slice per clock. It provides a start/done handshake and reports the final result with unsigned carry/borrow and signed overflow. It sits between the lab top-level (switch/button inputs) and the display logic, replacing a wide ripple adder with a small sequenced datapath.

---
 rtl/addsub_sequencer.sv | 104 ++++++++++
 tb/tb_addsub_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_sequencer.sv
// Sequenced WIDTH-bit add/sub: one 2-bit slice per clock, LSB pair first; done N+1 clocks after accept.
// No backpressure: start is sampled only in IDLE and ignored (not queued) while busy.
module addsub_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic             op_reg;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [1:0]       sa;
  logic [1:0]       sb;
  logic [1:0]       sum;
  logic             c0;
  logic             c1;
  logic             last;

  // The single shared 2-bit slice: B inverted for subtract, carry-in from the carry register.
  always_comb begin
    sa     = a_reg[{idx, 1'b0} +: 2];
    sb     = b_reg[{idx, 1'b0} +: 2] ^ {2{op_reg}};
    sum[0] = sa[0] ^ sb[0] ^ carry;
    c0     = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
    sum[1] = sa[1] ^ sb[1] ^ c0;
    c1     = (sa[1] & sb[1]) | (c0 & (sa[1] ^ sb[1]));
  end

  assign last = (idx == IW'(N - 1));
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      op_reg <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            op_reg <= op;
            idx    <= '0;
            carry  <= op;
            state  <= RUN;
          end
        end
        RUN: begin
          acc[{idx, 1'b0} +: 2] <= sum;
          carry                 <= c1;
          if (last) begin
            // On the top slice c0 is the carry into the MSB and c1 the carry out of it.
            result <= {sum, acc[WIDTH-3:0]};
            cout   <= c1 ^ op_reg;
            ovf    <= c1 ^ c0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_sequencer.sv
// Bench for addsub_sequencer: directed table, multi-cycle corner sequences and random ops vs a plain-arithmetic model.
module tb_addsub_sequencer;

  localparam int W = 8;
  localparam int N = W / 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;

  addsub_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for carry/borrow, signed range for overflow.
  task automatic model(input logic mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] r, output logic c, output logic v);
    int ua, ub, sa, sb, us, ss;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    us = mop ? (ua - ub) : (ua + ub);
    ss = mop ? (sa - sb) : (sa + sb);
    r  = W'(us & ((1 << W) - 1));
    c  = mop ? (ua < ub) : (us >= (1 << W));
    v  = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
  endtask

  // Issue one op and wait (bounded) for done; lat uses the cycle numbering where cycle E0+1 is the first RUN cycle.
  task automatic run_op(input logic mop, input logic [W-1:0] ma, input logic [W-1:0] mb, output int lat);
    start = 1'b1;
    op    = mop;
    a     = ma;
    b     = mb;
    tick();
    start = 1'b0;
    a     = ~ma;
    b     = ~mb;
    lat   = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
    end
  endtask

  vec_t vecs[8];

  initial begin
    int         lat;
    int         ndone;
    int         nlow;
    int         dcyc[$];
    logic [W-1:0] er;
    logic       ec;
    logic       ev;
    logic [W-1:0] held;

    vecs[0] = '{1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};

    // Reset state
    #3;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_result", 32'(result), 0);
    chk("reset_cout", 32'(cout), 0);
    chk("reset_ovf", 32'(ovf), 0);
    #9 rst_n = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), N + 1);
      chk($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].res));
      chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].co));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_busy_done", i), 32'(busy), 1);
      tick();
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 0);
      chk($sformatf("vec%0d_idle", i), 32'(busy), 0);
    end

    // Start during RUN and DONE is ignored; previous result held until the new done
    held  = result;
    start = 1'b1;
    op    = 1'b0;
    a     = 8'h10;
    b     = 8'h20;
    tick();
    a     = 8'hFF;
    b     = 8'hFF;
    op    = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20 && ndone == 0; k++) begin
      if (done) ndone++;
      else chk($sformatf("hold_result_c%0d", k), 32'(result), 32'(held));
      if (ndone == 0) tick();
    end
    chk("ignore_result", 32'(result), 8'h30);
    chk("ignore_cout", 32'(cout), 0);
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("ignore_single_done", 32'(ndone), 1);
    chk("ignore_idle_after", 32'(busy), 0);

    // Asynchronous reset in the 3rd RUN cycle
    start = 1'b1;
    op    = 1'b0;
    a     = 8'h55;
    b     = 8'h33;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_result", 32'(result), 0);
    chk("midrst_cout", 32'(cout), 0);
    chk("midrst_ovf", 32'(ovf), 0);
    tick();
    #2 rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 0);
    run_op(1'b0, 8'h01, 8'h01, lat);
    chk("post_rst_latency", 32'(lat), N + 1);
    chk("post_rst_result", 32'(result), 8'h02);
    tick();

    // Back-to-back with start held high
    start = 1'b1;
    op    = 1'b1;
    a     = 8'h90;
    b     = 8'h21;
    model(1'b1, 8'h90, 8'h21, er, ec, ev);
    nlow  = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) begin
        dcyc.push_back(k);
        chk($sformatf("b2b_result_%0d", dcyc.size()), 32'(result), 32'(er));
        chk($sformatf("b2b_ovf_%0d", dcyc.size()), 32'(ovf), 32'(ev));
      end
      if (!busy && dcyc.size() == 1) nlow++;
    end
    start = 1'b0;
    chk("b2b_done_count_ge4", 32'(dcyc.size() >= 4), 1);
    for (int j = 1; j < dcyc.size(); j++)
      chk($sformatf("b2b_interval_%0d", j), 32'(dcyc[j] - dcyc[j-1]), N + 2);
    chk("b2b_busy_low_cycles", 32'(nlow), 1);
    for (int k = 0; k < 10; k++) tick();

    // Random ops against the model
    for (int i = 0; i < 60; i++) begin
      logic         rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rop = 1'($urandom_range(0, 1));
      ra  = W'($urandom);
      rb  = W'($urandom);
      model(rop, ra, rb, er, ec, ev);
      run_op(rop, ra, rb, lat);
      chk($sformatf("rnd%0d_res op=%0d %0h,%0h", i, rop, ra, rb), 32'(result), 32'(er));
      chk($sformatf("rnd%0d_cout", i), 32'(cout), 32'(ec));
      chk($sformatf("rnd%0d_ovf", i), 32'(ovf), 32'(ev));
      if (i % 8 == 0) chk($sformatf("rnd%0d_latency", i), 32'(lat), N + 1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
